// File: rtl/exception_unit_if.sv
// Exception unit bus: commit-point inputs, CP0 exception/ERET strobes and
// the PC redirect toward fetch.
//
// Redirect handshake: redirect_valid is held high, with redirect_pc stable,
// until the first cycle in which redirect_valid & redirect_ready are both
// high; that cycle completes the transfer and redirect_valid drops next cycle.
interface exception_unit_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        exc_if_adel;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_mem_adel;
  logic        exc_mem_ades;
  logic [31:0] mem_addr;
  logic        is_eret;
  logic [7:0]  interrupt_info;
  logic [31:0] cp0_epc;
  logic        redirect_ready;
  logic        exception_enable;
  logic [4:0]  ecode;
  logic [31:0] exc_pc;
  logic [31:0] exc_addr;
  logic        exc_bd;
  logic        eret_enable;
  logic        commit_kill;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    input  commit_valid, commit_pc, commit_bd, exc_if_adel, exc_ri, exc_ov,
           exc_sys, exc_bp, exc_mem_adel, exc_mem_ades, mem_addr, is_eret,
           interrupt_info, cp0_epc, redirect_ready,
    output exception_enable, ecode, exc_pc, exc_addr, exc_bd, eret_enable,
           commit_kill, flush, stall, redirect_valid, redirect_pc
  );

  modport slave (
    output commit_valid, commit_pc, commit_bd, exc_if_adel, exc_ri, exc_ov,
           exc_sys, exc_bp, exc_mem_adel, exc_mem_ades, mem_addr, is_eret,
           interrupt_info, cp0_epc, redirect_ready,
    input  exception_enable, ecode, exc_pc, exc_addr, exc_bd, eret_enable,
           commit_kill, flush, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_unit.sv
// Precise-exception controller at the commit point. Picks the highest
// priority trap source, strobes CP0, flushes the pipe and holds a PC
// redirect toward fetch until fetch accepts it.
module exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic             clk,
  input  logic             resetn,
  exception_unit_if.master bus,
  output logic             o_dbg_state
);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_int_q;
  logic [31:0] r_redirect_pc;

  logic        w_sel;
  logic        w_sel_int;
  logic        w_addr_is_pc;
  logic [4:0]  w_ecode;
  logic        w_eval;
  logic        w_trap;
  logic        w_eret;

  assign o_dbg_state = r_state;

  // Fixed-priority trap source selection; the interrupt comes from the
  // registered vector so a fresh interrupt takes at least one cycle.
  always_comb begin
    w_sel        = 1'b1;
    w_sel_int    = 1'b0;
    w_addr_is_pc = 1'b0;
    w_ecode      = 5'h00;
    if (r_int_q) begin
      w_sel_int = 1'b1;
      w_ecode   = 5'h00;
    end else if (bus.exc_if_adel) begin
      w_addr_is_pc = 1'b1;
      w_ecode      = 5'h04;
    end else if (bus.exc_ri) begin
      w_ecode = 5'h0A;
    end else if (bus.exc_ov) begin
      w_ecode = 5'h0C;
    end else if (bus.exc_sys) begin
      w_ecode = 5'h08;
    end else if (bus.exc_bp) begin
      w_ecode = 5'h09;
    end else if (bus.exc_mem_adel) begin
      w_ecode = 5'h04;
    end else if (bus.exc_mem_ades) begin
      w_ecode = 5'h05;
    end else begin
      w_sel = 1'b0;
    end
  end

  // Next state and all outputs; an exception always beats ERET, and the
  // REDIRECT state ignores commits while keeping younger stages flushed.
  always_comb begin
    w_state_nxt          = r_state;
    w_eval               = resetn && bus.commit_valid && (r_state == S_IDLE);
    w_trap               = w_eval && w_sel;
    w_eret               = w_eval && !w_sel && bus.is_eret;
    bus.exception_enable = w_trap;
    bus.eret_enable      = w_eret;
    bus.commit_kill      = w_trap;
    bus.flush            = w_trap || w_eret || (r_state == S_REDIRECT);
    bus.stall            = (r_state == S_REDIRECT);
    bus.redirect_valid   = (r_state == S_REDIRECT);
    bus.redirect_pc      = r_redirect_pc;
    bus.ecode            = resetn ? w_ecode : 5'h00;
    bus.exc_pc           = resetn ? bus.commit_pc : 32'h0;
    bus.exc_bd           = resetn ? bus.commit_bd : 1'b0;
    bus.exc_addr         = 32'h0;
    if (resetn) begin
      bus.exc_addr = w_addr_is_pc ? bus.commit_pc : bus.mem_addr;
    end
    case (r_state)
      S_IDLE:     if (w_trap || w_eret) w_state_nxt = S_REDIRECT;
      S_REDIRECT: if (bus.redirect_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Interrupt sample; a taken interrupt is cleared so it is not retaken
  // before the vector is resampled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  r_int_q <= 1'b0;
    else if (w_trap && w_sel_int) r_int_q <= 1'b0;
    else                          r_int_q <= |bus.interrupt_info;
  end

  // Redirect target, latched when a trap or ERET is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_redirect_pc <= 32'h0;
    else if (w_trap) r_redirect_pc <= EXC_VECTOR;
    else if (w_eret) r_redirect_pc <= bus.cp0_epc;
  end

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed vectors, a per-cycle reference model
// built from the priority table, and literal spot checks.
module tb_exception_unit;

  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic clk;
  logic resetn;
  logic dbg_state;
  int   n_checks = 0;
  int   n_errors = 0;

  exception_unit_if bus ();

  exception_unit #(.EXC_VECTOR(EXC_VEC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Index into the priority list (0 = interrupt ... 7 = store misalign), -1 if none.
  function automatic int pick(input logic m_int_i);
    logic [7:0] src;
    src = {m_int_i, bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys,
           bus.exc_bp, bus.exc_mem_adel, bus.exc_mem_ades};
    for (int i = 0; i < 8; i++) if (src[7-i]) return i;
    return -1;
  endfunction

  function automatic logic [4:0] code_of(input int k);
    case (k)
      0: return 5'h00;
      1: return 5'h04;
      2: return 5'h0A;
      3: return 5'h0C;
      4: return 5'h08;
      5: return 5'h09;
      6: return 5'h04;
      7: return 5'h05;
      default: return 5'h00;
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic        m_int;
  logic        m_busy;
  logic [31:0] m_target;

  always @(posedge clk or negedge resetn) begin
    int k;
    logic ev, tr, er;
    if (!resetn) begin
      m_int    <= 1'b0;
      m_busy   <= 1'b0;
      m_target <= 32'h0;
    end else begin
      k  = pick(m_int);
      ev = bus.commit_valid && !m_busy;
      tr = ev && (k >= 0);
      er = ev && (k < 0) && bus.is_eret;
      if (m_busy) begin
        if (bus.redirect_ready) m_busy <= 1'b0;
      end else if (tr || er) begin
        m_busy   <= 1'b1;
        m_target <= tr ? EXC_VEC : bus.cp0_epc;
      end
      m_int <= (tr && k == 0) ? 1'b0 : |bus.interrupt_info;
    end
  end

  // Every cycle, compare outputs with the model half a cycle after the edge.
  always @(negedge clk) begin
    int k;
    logic ev, tr, er;
    if (!resetn) begin
      chk("rst_exc_en", {31'h0, bus.exception_enable}, 32'h0);
      chk("rst_eret_en", {31'h0, bus.eret_enable}, 32'h0);
      chk("rst_kill", {31'h0, bus.commit_kill}, 32'h0);
      chk("rst_flush", {31'h0, bus.flush}, 32'h0);
      chk("rst_stall", {31'h0, bus.stall}, 32'h0);
      chk("rst_rvalid", {31'h0, bus.redirect_valid}, 32'h0);
      chk("rst_rpc", bus.redirect_pc, 32'h0);
      chk("rst_ecode", {27'h0, bus.ecode}, 32'h0);
      chk("rst_exc_pc", bus.exc_pc, 32'h0);
      chk("rst_exc_addr", bus.exc_addr, 32'h0);
      chk("rst_exc_bd", {31'h0, bus.exc_bd}, 32'h0);
    end else begin
      k  = pick(m_int);
      ev = bus.commit_valid && !m_busy;
      tr = ev && (k >= 0);
      er = ev && (k < 0) && bus.is_eret;
      chk("m_exc_en", {31'h0, bus.exception_enable}, {31'h0, tr});
      chk("m_eret_en", {31'h0, bus.eret_enable}, {31'h0, er});
      chk("m_kill", {31'h0, bus.commit_kill}, {31'h0, tr});
      chk("m_flush", {31'h0, bus.flush}, {31'h0, tr || er || m_busy});
      chk("m_stall", {31'h0, bus.stall}, {31'h0, m_busy});
      chk("m_rvalid", {31'h0, bus.redirect_valid}, {31'h0, m_busy});
      chk("m_rpc", bus.redirect_pc, m_target);
      chk("m_dbg", {31'h0, dbg_state}, {31'h0, m_busy});
      if (tr) begin
        chk("m_ecode", {27'h0, bus.ecode}, {27'h0, code_of(k)});
        chk("m_exc_pc", bus.exc_pc, bus.commit_pc);
        chk("m_exc_bd", {31'h0, bus.exc_bd}, {31'h0, bus.commit_bd});
        if (k == 1) chk("m_addr_pc", bus.exc_addr, bus.commit_pc);
        if (k >= 6) chk("m_addr_mem", bus.exc_addr, bus.mem_addr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.commit_valid   = 1'b0;
    bus.commit_pc      = 32'h0;
    bus.commit_bd      = 1'b0;
    {bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_mem_adel, bus.exc_mem_ades} = 7'h0;
    bus.mem_addr       = 32'h0;
    bus.is_eret        = 1'b0;
    bus.interrupt_info = 8'h0;
    bus.redirect_ready = 1'b0;
  endtask

  // flags order: {if_adel, ri, ov, sys, bp, mem_adel, mem_ades}
  task automatic commit(input logic [31:0] pc, input logic bd, input logic [6:0] flags,
                        input logic [31:0] addr, input logic eret);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_bd    = bd;
    {bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_mem_adel, bus.exc_mem_ades} = flags;
    bus.mem_addr     = addr;
    bus.is_eret      = eret;
  endtask

  // One accepting cycle in REDIRECT, then back to an idle commit slot.
  task automatic finish_redirect();
    tick();
    set_idle();
    bus.redirect_ready = 1'b1;
    tick();
    set_idle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] lit_codes [7];
    lit_codes = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};

    resetn      = 1'b0;
    bus.cp0_epc = 32'h0;
    set_idle();
    repeat (2) @(posedge clk);
    sample();
    chk("reset_rvalid", {31'h0, bus.redirect_valid}, 32'h0);
    chk("reset_rpc", bus.redirect_pc, 32'h0);
    tick();
    resetn = 1'b1;

    // Syscall, not in a delay slot.
    tick();
    commit(32'hBFC0_0100, 1'b0, 7'b0001000, 32'h0, 1'b0);
    sample();
    chk("sys_en", {31'h0, bus.exception_enable}, 32'h1);
    chk("sys_ecode", {27'h0, bus.ecode}, 32'h08);
    chk("sys_pc", bus.exc_pc, 32'hBFC0_0100);
    tick();
    set_idle();
    bus.redirect_ready = 1'b1;
    sample();
    chk("sys_rvalid", {31'h0, bus.redirect_valid}, 32'h1);
    chk("sys_rpc", bus.redirect_pc, 32'hBFC0_0380);
    chk("sys_pulse", {31'h0, bus.exception_enable}, 32'h0);
    tick();
    set_idle();
    sample();
    chk("sys_done", {31'h0, bus.redirect_valid}, 32'h0);

    // Overflow beats store misalign; delay-slot flag passes through.
    tick();
    commit(32'h8000_1004, 1'b1, 7'b0010001, 32'h8000_0002, 1'b0);
    sample();
    chk("ov_ecode", {27'h0, bus.ecode}, 32'h0C);
    chk("ov_bd", {31'h0, bus.exc_bd}, 32'h1);
    chk("ov_pc", bus.exc_pc, 32'h8000_1004);
    finish_redirect();

    // Load misalign, then with a fetch misalign on top.
    commit(32'h8000_0040, 1'b0, 7'b0000010, 32'h8000_0003, 1'b0);
    sample();
    chk("adel_ecode", {27'h0, bus.ecode}, 32'h04);
    chk("adel_addr", bus.exc_addr, 32'h8000_0003);
    finish_redirect();
    commit(32'h8000_0400, 1'b0, 7'b1000010, 32'h8000_0003, 1'b0);
    sample();
    chk("ifadel_ecode", {27'h0, bus.ecode}, 32'h04);
    chk("ifadel_addr", bus.exc_addr, 32'h8000_0400);
    finish_redirect();

    // Each synchronous source alone.
    for (int i = 0; i < 7; i++) begin
      logic [6:0] f;
      f = 7'b1000000 >> i;
      commit(32'h8000_2000 + 32'(i * 4), 1'b0, f, 32'h1234_5670 + 32'(i), 1'b0);
      sample();
      chk("prio_ecode", {27'h0, bus.ecode}, {27'h0, lit_codes[i]});
      finish_redirect();
    end

    // Interrupt: one cycle of pending vector, commit on the following cycle.
    bus.interrupt_info = 8'h80;
    tick();
    set_idle();
    commit(32'h8000_3000, 1'b0, 7'h0, 32'h0, 1'b0);
    sample();
    chk("int_en", {31'h0, bus.exception_enable}, 32'h1);
    chk("int_ecode", {27'h0, bus.ecode}, 32'h00);
    chk("int_kill", {31'h0, bus.commit_kill}, 32'h1);
    finish_redirect();
    commit(32'h8000_3004, 1'b0, 7'h0, 32'h0, 1'b0);
    sample();
    chk("int_cleared", {31'h0, bus.exception_enable}, 32'h0);
    tick();
    set_idle();

    // ERET with a held-off redirect; a commit during the hold is ignored.
    bus.cp0_epc = 32'h8000_0200;
    commit(32'h8000_0300, 1'b0, 7'h0, 32'h0, 1'b1);
    sample();
    chk("eret_en", {31'h0, bus.eret_enable}, 32'h1);
    chk("eret_exc", {31'h0, bus.exception_enable}, 32'h0);
    chk("eret_kill", {31'h0, bus.commit_kill}, 32'h0);
    chk("eret_flush", {31'h0, bus.flush}, 32'h1);
    for (int h = 0; h < 3; h++) begin
      tick();
      set_idle();
      if (h == 1) commit(32'h8000_0304, 1'b0, 7'b0001000, 32'h0, 1'b0);
      sample();
      chk("hold_rvalid", {31'h0, bus.redirect_valid}, 32'h1);
      chk("hold_stall", {31'h0, bus.stall}, 32'h1);
      chk("hold_flush", {31'h0, bus.flush}, 32'h1);
      chk("hold_rpc", bus.redirect_pc, 32'h8000_0200);
      chk("hold_exc", {31'h0, bus.exception_enable}, 32'h0);
      chk("hold_eret", {31'h0, bus.eret_enable}, 32'h0);
    end
    tick();
    set_idle();
    bus.redirect_ready = 1'b1;
    sample();
    chk("hold_last", {31'h0, bus.redirect_valid}, 32'h1);
    tick();
    set_idle();
    sample();
    chk("hold_done", {31'h0, bus.redirect_valid}, 32'h0);

    // Exception on an ERET instruction wins; no ERET strobe.
    tick();
    commit(32'h8000_0500, 1'b0, 7'b0100000, 32'h0, 1'b1);
    sample();
    chk("eretx_ecode", {27'h0, bus.ecode}, 32'h0A);
    chk("eretx_eret", {31'h0, bus.eret_enable}, 32'h0);
    chk("eretx_exc", {31'h0, bus.exception_enable}, 32'h1);
    finish_redirect();

    // Asynchronous reset while a redirect is outstanding.
    commit(32'h8000_0600, 1'b0, 7'b0000100, 32'h0, 1'b0);
    tick();
    set_idle();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_rvalid", {31'h0, bus.redirect_valid}, 32'h0);
    chk("arst_stall", {31'h0, bus.stall}, 32'h0);
    chk("arst_rpc", bus.redirect_pc, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    commit(32'h8000_0010, 1'b0, 7'b0001000, 32'h0, 1'b0);
    sample();
    chk("post_en", {31'h0, bus.exception_enable}, 32'h1);
    chk("post_ecode", {27'h0, bus.ecode}, 32'h08);
    tick();
    set_idle();
    sample();
    chk("post_rpc", bus.redirect_pc, 32'hBFC0_0380);
    finish_redirect();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
# exception_unit

Precise-exception controller at the commit point of the MIPS pipeline, acting as the initiator side of the CP0 exception/ERET interface. Each cycle it examines the instruction committing from the memory stage and the registered CP0 interrupt vector. It selects at most one trap source by priority and drives the one-cycle exception or ERET strobe into CP0. It then flushes the pipeline and holds a PC redirect toward fetch until fetch accepts it.

## Interface
- Parameters:
- EXC_VECTOR, 32'hBFC0_0380, handler entry PC for all exceptions and interrupts
- Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- commit_valid  in  1  an instruction is at the commit point this cycle
- commit_pc  in  32  PC of committing instruction
- commit_bd  in  1  committing instruction sits in a branch delay slot
- exc_if_adel  in  1  fetch address misaligned
- exc_ri  in  1  reserved instruction
- exc_ov  in  1  arithmetic overflow
- exc_sys  in  1  syscall
- exc_bp  in  1  break
- exc_mem_adel  in  1  load address misaligned
- exc_mem_ades  in  1  store address misaligned
- mem_addr  in  32  data virtual address of committing load/store
- is_eret  in  1  committing instruction is ERET
- interrupt_info  in  8  masked pending interrupts from CP0 (already gated by IE/EXL)
- cp0_epc  in  32  current EPC from CP0
- redirect_ready  in  1  fetch accepts redirect this cycle
- exception_enable  out  1  CP0 exception strobe
- ecode  out  5  CP0 ExcCode
- exc_pc  out  32  faulting PC to CP0
- exc_addr  out  32  BadVAddr candidate to CP0
- exc_bd  out  1  delay-slot flag to CP0
- eret_enable  out  1  CP0 ERET strobe
- commit_kill  out  1  suppress register/memory side effects of committing instruction
- flush  out  1  invalidate all younger pipeline stages
- stall  out  1  freeze commit while a redirect is outstanding
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  target PC

## Operation
- int_q <= |interrupt_info, registered each cycle; reset 0.
- The trap decision is evaluated only when commit_valid is high and the state is IDLE.
- Priority, highest first, with ecode:
  - interrupt (int_q) 0x00
  - exc_if_adel 0x04, exc_addr = commit_pc
  - exc_ri 0x0A
  - exc_ov 0x0C
  - exc_sys 0x08
  - exc_bp 0x09
  - exc_mem_adel 0x04, exc_addr = mem_addr
  - exc_mem_ades 0x05, exc_addr = mem_addr
- When no source is selected, exc_addr = mem_addr and ecode = 0.
- Trap taken:
  - exception_enable = 1, commit_kill = 1, flush = 1.
  - exc_pc = commit_pc and exc_bd = commit_bd, unmodified; CP0 applies the delay-slot PC-4 correction.
  - Target latched as EXC_VECTOR.
  - An interrupt also clears int_q in the same edge, so that interrupt is not retaken until resampled.
- ERET with no trap selected:
  - eret_enable = 1, flush = 1, commit_kill = 0.
  - Target latched as cp0_epc sampled in the same cycle.
- An exception always wins over ERET on the same instruction; eret_enable stays 0.
- State machine:
  - IDLE: on trap or ERET, latch redirect_pc and go to REDIRECT.
  - REDIRECT: redirect_valid = 1 and stall = 1. On redirect_ready go to IDLE.
  - In REDIRECT, commit_valid is ignored: no strobes, no kill, and flush stays asserted.
- The EXL state in CP0 does not gate synchronous exceptions; it gates interrupts only through interrupt_info.

## Timing
- Decision is combinational in cycle T. exception_enable, eret_enable, commit_kill and flush are asserted in T, so CP0 captures at the T→T+1 edge.
- exception_enable and eret_enable are single-cycle pulses per trap. They are never both high.
- redirect_valid rises at T+1. redirect_pc stays stable while redirect_valid is high.
- A redirect completes at the first cycle with redirect_valid & redirect_ready; redirect_valid is low the next cycle.
- Minimum spacing between two traps is 2 cycles: trap in T, ready in T+1, next trap in T+2.
- interrupt_info → trap takes at least 1 cycle, via int_q.
- Reset, asynchronous and effective mid-REDIRECT:
  - State IDLE, int_q = 0, redirect_pc = 0.
  - All strobes, flush, stall and redirect_valid are 0.
  - ecode = 0, exc_pc = 0, exc_addr = 0, exc_bd = 0.

## Test plan
- Syscall at PC 0xBFC00100 with commit_bd = 0:
  - One-cycle exception_enable, ecode 0x08, exc_pc 0xBFC00100.
  - redirect_pc 0xBFC00380 from the next cycle.
- exc_ov and exc_mem_ades together, PC 0x80001004, commit_bd = 1: ecode 0x0C, exc_bd 1, exc_pc 0x80001004.
- Load to 0x80000003 with exc_mem_adel: ecode 0x04, exc_addr 0x80000003. Same case with exc_if_adel also set: exc_addr = commit_pc.
- interrupt_info = 0x80 for one cycle, commit_valid on the next cycle: ecode 0x00, commit_kill 1, and int_q clears.
- ERET with cp0_epc = 0x80000200, redirect_ready held low 3 cycles:
  - eret_enable for 1 cycle.
  - redirect_valid, stall and flush high for 4 cycles with pc 0x80000200.
  - A second commit_valid during the hold is ignored.
- resetn dropped in REDIRECT: redirect_valid falls immediately. After release, the first trap behaves normally.
